result_capture: RTL and testbench

RESULT_CAPTURE -- requirements
Module: result_capture

---
 rtl/result_pkg.sv | 14 +
 rtl/result_channel.sv | 87 ++++++++
 rtl/result_capture.sv | 44 ++++
 tb/tb_result_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared defaults and per-channel flag encoding
// for the result capture block.
package result_pkg;

    localparam int DEF_WIDTH    = 10;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic {
        FLAG_IDLE    = 1'b0,
        FLAG_PENDING = 1'b1
    } flag_state_e;

endpackage

// File: rtl/result_channel.sv
// One capture channel: last value, peak,
// saturating count, unread flag and drop flag.
module result_channel
    import result_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result_in,
    input  logic             in_valid,
    input  logic             freeze,
    input  logic             clear,
    input  logic             ack,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] peak_out,
    output logic [CNT_W-1:0] capture_cnt,
    output logic             new_flag,
    output logic             dropped
);

    flag_state_e      state_q;
    flag_state_e      state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] peak_q;
    logic [WIDTH-1:0] peak_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drop_q;
    logic             drop_d;
    logic             capture;

    assign capture = in_valid && !freeze && !clear;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FLAG_IDLE:    if (capture) state_d = FLAG_PENDING;
            FLAG_PENDING: if (!capture && ack) state_d = FLAG_IDLE;
            default:      state_d = FLAG_IDLE;
        endcase
        if (clear) state_d = FLAG_IDLE;
    end

    always_comb begin
        result_d = result_q;
        peak_d   = peak_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        if (clear) begin
            peak_d = '0;
            cnt_d  = '0;
            drop_d = 1'b0;
        end else if (capture) begin
            result_d = result_in;
            if (result_in > peak_q) peak_d = result_in;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else if (in_valid && freeze) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FLAG_IDLE;
            result_q <= '0;
            peak_q   <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            peak_q   <= peak_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    assign result_out  = result_q;
    assign peak_out    = peak_q;
    assign capture_cnt = cnt_q;
    assign new_flag    = (state_q == FLAG_PENDING);
    assign dropped     = drop_q;

endmodule

// File: rtl/result_capture.sv
// Multi-channel result capture: one independent
// result_channel per lane, packed on the ports.
module result_capture
    import result_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] result_in,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic                      freeze,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS*WIDTH-1:0] result_out,
    output logic [CHANNELS*WIDTH-1:0] peak_out,
    output logic [CHANNELS*CNT_W-1:0] capture_cnt,
    output logic [CHANNELS-1:0]       new_flag,
    output logic [CHANNELS-1:0]       dropped
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        result_channel #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .result_in   (result_in[k*WIDTH +: WIDTH]),
            .in_valid    (in_valid[k]),
            .freeze      (freeze),
            .clear       (clear),
            .ack         (ack[k]),
            .result_out  (result_out[k*WIDTH +: WIDTH]),
            .peak_out    (peak_out[k*WIDTH +: WIDTH]),
            .capture_cnt (capture_cnt[k*CNT_W +: CNT_W]),
            .new_flag    (new_flag[k]),
            .dropped     (dropped[k])
        );
    end

endmodule

// File: tb/tb_result_capture.sv
// Scoreboard bench for result_capture, run with
// CNT_W=2 so counter saturation is reachable.
module tb_result_capture;

    localparam int W  = 10;
    localparam int CH = 2;
    localparam int CW = 2;

    typedef struct packed {
        logic [CH*W-1:0]  res;
        logic [CH*W-1:0]  peak;
        logic [CH*CW-1:0] cnt;
        logic [CH-1:0]    nf;
        logic [CH-1:0]    dr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*W-1:0]  result_in;
    logic [CH-1:0]    in_valid;
    logic             freeze;
    logic             clear;
    logic [CH-1:0]    ack;
    logic [CH*W-1:0]  result_out;
    logic [CH*W-1:0]  peak_out;
    logic [CH*CW-1:0] capture_cnt;
    logic [CH-1:0]    new_flag;
    logic [CH-1:0]    dropped;

    exp_t obs;
    exp_t m;
    exp_t e;
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    result_capture #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .result_in   (result_in),
        .in_valid    (in_valid),
        .freeze      (freeze),
        .clear       (clear),
        .ack         (ack),
        .result_out  (result_out),
        .peak_out    (peak_out),
        .capture_cnt (capture_cnt),
        .new_flag    (new_flag),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    assign obs = {result_out, peak_out, capture_cnt, new_flag, dropped};

    // Drive one cycle, push the model's expected state, wait past the edge.
    task automatic step(input logic r, input logic [CH*W-1:0] d,
                        input logic [CH-1:0] v, input logic f,
                        input logic c, input logic [CH-1:0] a);
        @(negedge clk);
        rst = r; result_in = d; in_valid = v;
        freeze = f; clear = c; ack = a;
        for (int k = 0; k < CH; k++) begin
            logic [W-1:0] x;
            x = d[k*W +: W];
            if (r) begin
                m.res[k*W +: W] = '0;
                m.peak[k*W +: W] = '0;
                m.cnt[k*CW +: CW] = '0;
                m.nf[k] = 1'b0;
                m.dr[k] = 1'b0;
            end else if (c) begin
                m.peak[k*W +: W] = '0;
                m.cnt[k*CW +: CW] = '0;
                m.nf[k] = 1'b0;
                m.dr[k] = 1'b0;
            end else begin
                if (v[k] && f) m.dr[k] = 1'b1;
                if (v[k] && !f) begin
                    m.res[k*W +: W] = x;
                    if (x > m.peak[k*W +: W]) m.peak[k*W +: W] = x;
                    if (m.cnt[k*CW +: CW] < CW'((1 << CW) - 1))
                        m.cnt[k*CW +: CW] = m.cnt[k*CW +: CW] + 1'b1;
                    m.nf[k] = 1'b1;
                end else if (a[k]) begin
                    m.nf[k] = 1'b0;
                end
            end
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = '0; freeze = 1'b0;
        clear = 1'b0; ack = '0;
    endtask

    task automatic test_reset();
        step(1'b1, '0, '0, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || obs !== '0) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_capture();
        step(1'b0, {10'd0, 10'd37}, 2'b01, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL capture_sb got=%h exp=%h", obs, e);
        end
        checks++;
        if (result_out[9:0] !== 10'd37 || peak_out[9:0] !== 10'd37 ||
            capture_cnt[1:0] !== 2'd1 || new_flag !== 2'b01 ||
            result_out[19:10] !== '0 || peak_out[19:10] !== '0 ||
            capture_cnt[3:2] !== '0 || dropped !== '0) begin
            failures++;
            $display("FAIL capture_37 got=%h exp res0=37 peak0=37 cnt0=1 nf=01", obs);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || result_out[9:0] !== 10'd37) begin
            failures++;
            $display("FAIL hold got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_peak();
        step(1'b0, {10'd0, 10'd500}, 2'b01, 1'b0, 1'b1, '0);
        e = sb_q.pop_front();
        step(1'b0, {10'd0, 10'd500}, 2'b01, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        step(1'b0, {10'd0, 10'd120}, 2'b01, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || result_out[9:0] !== 10'd120 ||
            peak_out[9:0] !== 10'd500 || capture_cnt[1:0] !== 2'd2) begin
            failures++;
            $display("FAIL peak got=%h exp res0=120 peak0=500 cnt0=2", obs);
        end
        step(1'b0, {10'd0, 10'd500}, 2'b01, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || peak_out[9:0] !== 10'd500) begin
            failures++;
            $display("FAIL peak_equal got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_saturate();
        logic [CW-1:0] want [5];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, {10'(i + 3), 10'd0}, 2'b10, 1'b0, 1'b0, '0);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e || capture_cnt[3:2] !== want[i]) begin
                failures++;
                $display("FAIL saturate i=%0d cnt1=%0d exp=%0d", i,
                         capture_cnt[3:2], want[i]);
            end
        end
    endtask

    task automatic test_freeze();
        logic [W-1:0] keep;
        step(1'b0, {10'd0, 10'd64}, 2'b01, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        keep = result_out[9:0];
        step(1'b0, {10'd0, 10'd999}, 2'b01, 1'b1, 1'b0, 2'b01);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || result_out[9:0] !== keep || dropped[0] !== 1'b1 ||
            new_flag[0] !== 1'b0) begin
            failures++;
            $display("FAIL freeze got=%h exp res0=%0d dr0=1 nf0=0", obs, keep);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || dropped !== '0 || peak_out !== '0 ||
            capture_cnt !== '0 || result_out[9:0] !== keep) begin
            failures++;
            $display("FAIL clear got=%h exp=%h", obs, e);
        end
        step(1'b0, {10'd5, 10'd5}, 2'b11, 1'b1, 1'b1, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || dropped !== '0 || capture_cnt !== '0) begin
            failures++;
            $display("FAIL clear_prio got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_ack();
        step(1'b0, '0, '0, 1'b0, 1'b0, 2'b11);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || new_flag !== '0) begin
            failures++;
            $display("FAIL ack_idle got=%h exp=%h", obs, e);
        end
        step(1'b0, {10'd7, 10'd0}, 2'b10, 1'b0, 1'b0, 2'b10);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || new_flag[1] !== 1'b1 || result_out[19:10] !== 10'd7) begin
            failures++;
            $display("FAIL ack_same got nf1=%b exp=1", new_flag[1]);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, 2'b10);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || new_flag[1] !== 1'b0) begin
            failures++;
            $display("FAIL ack_alone got nf1=%b exp=0", new_flag[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, CH*W'($urandom), CH'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                 CH'($urandom));
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random i=%0d got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, {10'd300, 10'd200}, 2'b11, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        step(1'b1, {10'd42, 10'd42}, 2'b11, 1'b1, 1'b1, 2'b11);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || obs !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0", obs);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, '0);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e || result_out !== '0) begin
            failures++;
            $display("FAIL reset_after got=%h exp=%h", obs, e);
        end
    endtask

    initial begin
        m = '0;
        rst = 1'b1; result_in = '0; in_valid = '0;
        freeze = 1'b0; clear = 1'b0; ack = '0;
        test_reset();
        test_capture();
        test_peak();
        test_saturate();
        test_freeze();
        test_ack();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
